// File: rtl/mcp23017_pkg.sv
// Shared definitions for the MCP23017-compatible I2C target.
// Holds the register map, the FSM state type and the pointer arithmetic helpers.
package mcp23017_pkg;

    localparam logic [7:0] REG_IODIRA = 8'h00;
    localparam logic [7:0] REG_IODIRB = 8'h01;
    localparam logic [7:0] REG_IPOLA  = 8'h02;
    localparam logic [7:0] REG_IPOLB  = 8'h03;
    localparam logic [7:0] REG_GPPUA  = 8'h0C;
    localparam logic [7:0] REG_GPPUB  = 8'h0D;
    localparam logic [7:0] REG_GPIOA  = 8'h12;
    localparam logic [7:0] REG_GPIOB  = 8'h13;
    localparam logic [7:0] REG_OLATA  = 8'h14;
    localparam logic [7:0] REG_OLATB  = 8'h15;
    localparam logic [7:0] REG_LAST   = 8'h15;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    // Out-of-range pointer bytes fold back into the 22-entry map.
    function automatic logic [7:0] ptr_wrap(input logic [7:0] b);
        return b % 8'd22;
    endfunction

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == REG_LAST) ? 8'h00 : p + 8'h01;
    endfunction

endpackage

// File: rtl/i2c_target_phy.sv
// Synchronizes raw SCL/SDA into clk_i and flags SCL edges plus START/STOP.
// Stage [1] is the synchronized level, stage [2] its previous value.
module i2c_target_phy (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            // NOTE: sequential state is assigned with <= only, so every stage sees the old value.
            r_scl <= {r_scl[1:0], scl_i};
            r_sda <= {r_sda[1:0], sda_i};
        end
    end

    assign sda_o      = r_sda[1];
    assign scl_rise_o = r_scl[1] & ~r_scl[2];
    assign scl_fall_o = ~r_scl[1] & r_scl[2];
    assign start_o    = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
    assign stop_o     = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/mcp23017_target.sv
// I2C target exposing an MCP23017-style register map over two 8-bit ports.
// SDA is only ever pulled low in ACK windows or while returning read data.
module mcp23017_target
    import mcp23017_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'b010_0000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    input  logic [7:0] porta_i,
    input  logic [7:0] portb_i,
    output logic [7:0] porta_o,
    output logic [7:0] portb_o,
    output logic [7:0] porta_oe_o,
    output logic [7:0] portb_oe_o,
    output logic [7:0] porta_pu_o,
    output logic [7:0] portb_pu_o,
    output logic       wr_stb_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);
    logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_rx_byte, w_rd_data;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift, r_ptr;
    logic       r_sda_t, r_ack_on, r_rw;
    logic       r_wr_stb;
    logic [7:0] r_wr_addr, r_wr_data;
    logic [7:0] r_iodira, r_iodirb, r_ipola, r_ipolb;
    logic [7:0] r_gppua, r_gppub, r_olata, r_olatb;

    i2c_target_phy u_phy (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (w_sda),
        .scl_rise_o (w_scl_rise),
        .scl_fall_o (w_scl_fall),
        .start_o    (w_start),
        .stop_o     (w_stop)
    );

    assign w_rx_byte = {r_shift[6:0], w_sda};

    always_comb begin
        // NOTE: default first so no latch is inferred for unmapped pointers.
        w_rd_data = 8'h00;
        case (r_ptr)
            REG_IODIRA: w_rd_data = r_iodira;
            REG_IODIRB: w_rd_data = r_iodirb;
            REG_IPOLA:  w_rd_data = r_ipola;
            REG_IPOLB:  w_rd_data = r_ipolb;
            REG_GPPUA:  w_rd_data = r_gppua;
            REG_GPPUB:  w_rd_data = r_gppub;
            REG_GPIOA:  w_rd_data = (r_iodira & (porta_i ^ r_ipola)) | (~r_iodira & r_olata);
            REG_GPIOB:  w_rd_data = (r_iodirb & (portb_i ^ r_ipolb)) | (~r_iodirb & r_olatb);
            REG_OLATA:  w_rd_data = r_olata;
            REG_OLATB:  w_rd_data = r_olatb;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_ptr     <= 8'h00;
            r_sda_t   <= 1'b1;
            r_ack_on  <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state   <= ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_t   <= 1'b1;
                r_ack_on  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= IDLE;
                r_sda_t  <= 1'b1;
                r_ack_on <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR, WDATA: if (w_scl_rise) begin
                        r_shift   <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_state == ADDR) begin
                                r_rw    <= w_rx_byte[0];
                                r_state <= (w_rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
                            end else if (r_state == PTR) begin
                                r_ptr   <= ptr_wrap(w_rx_byte);
                                r_state <= PTR_ACK;
                            end else begin
                                r_wr_stb  <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_rx_byte;
                                r_ptr     <= ptr_inc(r_ptr);
                                r_state   <= WDATA_ACK;
                            end
                        end
                    end
                    // First SCL fall opens the ACK window, the second one closes it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_sda_t  <= 1'b0;
                            r_ack_on <= 1'b1;
                        end else begin
                            r_ack_on  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                r_state <= RDATA;
                                r_shift <= w_rd_data;
                                r_sda_t <= w_rd_data[7];
                            end else begin
                                r_state <= (r_state == ADDR_ACK) ? PTR : WDATA;
                                r_sda_t <= 1'b1;
                            end
                        end
                    end
                    RDATA: begin
                        if (w_scl_fall) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_sda_t <= r_shift[6];
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_state <= RACK;
                        end
                    end
                    RACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_on) begin
                                r_sda_t  <= 1'b1;
                                r_ack_on <= 1'b1;
                            end else begin
                                r_ack_on  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= RDATA;
                                r_shift   <= w_rd_data;
                                r_sda_t   <= w_rd_data[7];
                            end
                        end else if (w_scl_rise && r_ack_on) begin
                            r_ptr <= ptr_inc(r_ptr);
                            if (w_sda) begin
                                r_state  <= IDLE;
                                r_ack_on <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Register file is written the cycle after the strobe; GPIOx aliases OLATx.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_iodira <= 8'hFF;
            r_iodirb <= 8'hFF;
            r_ipola  <= 8'h00;
            r_ipolb  <= 8'h00;
            r_gppua  <= 8'h00;
            r_gppub  <= 8'h00;
            r_olata  <= 8'h00;
            r_olatb  <= 8'h00;
        end else if (r_wr_stb) begin
            case (r_wr_addr)
                REG_IODIRA:            r_iodira <= r_wr_data;
                REG_IODIRB:            r_iodirb <= r_wr_data;
                REG_IPOLA:             r_ipola  <= r_wr_data;
                REG_IPOLB:             r_ipolb  <= r_wr_data;
                REG_GPPUA:             r_gppua  <= r_wr_data;
                REG_GPPUB:             r_gppub  <= r_wr_data;
                REG_GPIOA, REG_OLATA:  r_olata  <= r_wr_data;
                REG_GPIOB, REG_OLATB:  r_olatb  <= r_wr_data;
                default:               ;
            endcase
        end
    end

    assign sda_o      = 1'b0;
    assign sda_t      = r_sda_t;
    assign porta_o    = r_olata;
    assign portb_o    = r_olatb;
    assign porta_oe_o = ~r_iodira;
    assign portb_oe_o = ~r_iodirb;
    assign porta_pu_o = r_gppua;
    assign portb_pu_o = r_gppub;
    assign wr_stb_o   = r_wr_stb;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;

endmodule

// File: tb/tb_mcp23017_target.sv
// Bench for mcp23017_target: bit-banged I2C controller on an open-drain SDA model.
// Expected register writes are queued and matched by a monitor on wr_stb_o.
`timescale 1ns/1ps
module tb_mcp23017_target;

    localparam int Q = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_ctl = 1'b1;
    logic       sda_ctl = 1'b1;
    logic [7:0] porta_i = 8'h00;
    logic [7:0] portb_i = 8'h00;
    logic       sda_bus, sda_o, sda_t, wr_stb_o;
    logic [7:0] porta_o, portb_o, porta_oe_o, portb_oe_o, porta_pu_o, portb_pu_o;
    logic [7:0] wr_addr_o, wr_data_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          low_cnt  = 0;
    logic [15:0] exp_q[$];

    assign sda_bus = sda_ctl & (sda_t ? 1'b1 : sda_o);

    mcp23017_target #(.DEV_ADDR(7'b010_0000)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_ctl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .sda_t      (sda_t),
        .porta_i    (porta_i),
        .portb_i    (portb_i),
        .porta_o    (porta_o),
        .portb_o    (portb_o),
        .porta_oe_o (porta_oe_o),
        .portb_oe_o (portb_oe_o),
        .porta_pu_o (porta_pu_o),
        .portb_pu_o (portb_pu_o),
        .wr_stb_o   (wr_stb_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (!scl_ctl) begin
            sda_ctl = 1'b1; tick(Q);
            scl_ctl = 1'b1; tick(Q);
        end
        sda_ctl = 1'b0; tick(Q);
        scl_ctl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; tick(Q);
        scl_ctl = 1'b1; tick(Q);
        sda_ctl = 1'b1; tick(2 * Q);
    endtask

    task automatic bit_cycle(input logic b, output logic s);
        sda_ctl = b;    tick(Q);
        scl_ctl = 1'b1; tick(Q);
        s = sda_bus;    tick(Q);
        scl_ctl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], d);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) bit_cycle(1'b1, b[i]);
        bit_cycle(nack, d);
    endtask

    task automatic write_txn(input logic [7:0] ptr, input int n,
                             input logic [7:0] d [4], input logic [7:0] ea [4]);
        logic ack;
        i2c_start();
        write_byte(8'h40, ack); check("wr_addr_ack", ack, 0);
        write_byte(ptr, ack);   check("wr_ptr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ea[i], d[i]});
            write_byte(d[i], ack); check("wr_data_ack", ack, 0);
        end
        i2c_stop();
    endtask

    // Leaves the bus after the final NACK so the caller can probe before STOP.
    task automatic read_txn(input logic [7:0] ptr, input int n, input logic [7:0] e [4]);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        write_byte(8'h40, ack); check("rd_waddr_ack", ack, 0);
        write_byte(ptr, ack);   check("rd_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h41, ack); check("rd_raddr_ack", ack, 0);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            check("rd_byte", b, e[i]);
        end
    endtask

    task automatic run_tests();
        logic       ack;
        logic [7:0] b;
        int         lc0;

        tick(3);
        check("rst_sda_t", sda_t, 1);
        check("rst_sda_o", sda_o, 0);
        check("rst_wr_stb", wr_stb_o, 0);
        check("rst_porta_oe", porta_oe_o, 8'h00);
        check("rst_portb_oe", portb_oe_o, 8'h00);
        check("rst_porta_o", porta_o, 8'h00);
        check("rst_portb_pu", portb_pu_o, 8'h00);
        rst = 1'b0;
        tick(5);

        write_txn(8'h00, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
        check("t1_porta_oe", porta_oe_o, 8'hFF);
        check("t1_portb_oe", portb_oe_o, 8'h00);

        write_txn(8'h14, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, '{8'h14, 8'h15, 8'h00, 8'h00});
        check("t2_porta_o", porta_o, 8'h11);
        check("t2_portb_o", portb_o, 8'h22);
        check("t2_porta_oe", porta_oe_o, 8'hCC);

        write_txn(8'h0C, 2, '{8'h3C, 8'hC3, 8'h00, 8'h00}, '{8'h0C, 8'h0D, 8'h00, 8'h00});
        check("pu_porta", porta_pu_o, 8'h3C);
        check("pu_portb", portb_pu_o, 8'hC3);

        write_txn(8'h03, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, '{8'h03, 8'h00, 8'h00, 8'h00});
        portb_i = 8'h0F;
        read_txn(8'h13, 1, '{8'hF0, 8'h00, 8'h00, 8'h00});
        lc0 = low_cnt;
        read_byte(1'b1, b);
        check("t3_idle_byte", b, 8'hFF);
        check("t3_idle_sda_low", low_cnt - lc0, 0);
        i2c_stop();

        write_txn(8'h00, 1, '{8'h0F, 8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
        write_txn(8'h14, 1, '{8'hA0, 8'h00, 8'h00, 8'h00}, '{8'h14, 8'h00, 8'h00, 8'h00});
        porta_i = 8'h05;
        read_txn(8'h12, 1, '{8'hA5, 8'h00, 8'h00, 8'h00});
        i2c_stop();
        read_txn(8'h14, 2, '{8'hA0, 8'h22, 8'h00, 8'h00});
        i2c_stop();

        write_txn(8'h13, 1, '{8'h5A, 8'h00, 8'h00, 8'h00}, '{8'h13, 8'h00, 8'h00, 8'h00});
        check("gpiob_to_olatb", portb_o, 8'h5A);
        write_txn(8'h2A, 1, '{8'h77, 8'h00, 8'h00, 8'h00}, '{8'h14, 8'h00, 8'h00, 8'h00});
        check("ptr_mod22", porta_o, 8'h77);
        write_txn(8'h05, 1, '{8'h99, 8'h00, 8'h00, 8'h00}, '{8'h05, 8'h00, 8'h00, 8'h00});
        read_txn(8'h05, 1, '{8'h00, 8'h00, 8'h00, 8'h00});
        i2c_stop();

        lc0 = low_cnt;
        i2c_start();
        write_byte(8'h42, ack); check("t5_addr_nack", ack, 1);
        write_byte(8'h12, ack); check("t5_data_nack", ack, 1);
        i2c_stop();
        check("t5_sda_low_cycles", low_cnt - lc0, 0);

        i2c_start();
        write_byte(8'h40, ack); check("t6_waddr_ack", ack, 0);
        write_byte(8'h00, ack); check("t6_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h41, ack); check("t6_raddr_ack", ack, 0);
        for (int k = 0; k < 64 && sda_t; k++) tick(1);
        check("t6_drive_zero_bit", sda_t, 0);
        rst = 1'b1;
        #1;
        check("t6_sda_t_async", sda_t, 1);
        sda_ctl = 1'b1;
        scl_ctl = 1'b1;
        tick(4);
        check("t6_porta_oe", porta_oe_o, 8'h00);
        check("t6_portb_o", portb_o, 8'h00);
        check("t6_porta_o", porta_o, 8'h00);
        check("t6_porta_pu", porta_pu_o, 8'h00);
        rst = 1'b0;
        tick(2 * Q);
        scl_ctl = 1'b0;
        tick(Q);
        write_byte(8'h40, ack); check("t6_no_start_nack", ack, 1);
        i2c_stop();

        tick(10);
        check("wr_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            begin : monitor
                logic [15:0] e;
                forever begin
                    @(negedge clk);
                    if (!sda_t) low_cnt++;
                    if (wr_stb_o) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL wr_unexpected: addr 0x%02h data 0x%02h with none expected",
                                     wr_addr_o, wr_data_o);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", wr_addr_o, e[15:8]);
                            check("wr_data", wr_data_o, e[7:0]);
                        end
                    end
                end
            end
            begin
                run_tests();
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        join
    end

endmodule
